// File: rtl/dp_alu_pipe.sv
// rtl/dp_alu_pipe.sv - two-stage ARM-style data-processing ALU with barrel shifter and NZCV flags
module dp_alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [SW-1:0]    shamt,
    input  logic [1:0]       shift_type,
    input  logic [3:0]       opcode,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [3:0]       flags
);

    logic             s1Valid;
    logic [WIDTH-1:0] s1A;
    logic [WIDTH-1:0] s1B;
    logic             s1ShC;
    logic             s1UseC;
    logic [3:0]       s1Op;
    logic             s1S;

    logic s2Advance;
    logic s1Advance;

    assign s2Advance = !out_valid || out_ready;
    assign s1Advance = !s1Valid || s2Advance;
    assign in_ready  = !reset && s1Advance;

    // Shifter: the extra bit beyond the datapath catches the last bit shifted out.
    logic [WIDTH:0]   lslWide;
    logic [WIDTH:0]   lsrWide;
    logic [WIDTH:0]   asrWide;
    logic [SW-2:0]    rotAmt;
    logic [SW-1:0]    rotInv;
    logic [WIDTH-1:0] rotVal;
    logic [WIDTH-1:0] shOut;
    logic             shC;
    logic             useC;

    always_comb begin
        lslWide = {1'b0, op_b} << shamt;
        lsrWide = {op_b, 1'b0} >> shamt;
        asrWide = $signed({op_b, 1'b0}) >>> shamt;
        rotAmt  = shamt[SW-2:0];
        rotInv  = SW'(WIDTH) - {1'b0, rotAmt};
        rotVal  = (op_b >> rotAmt) | (op_b << rotInv);
        shOut   = op_b;
        shC     = 1'b0;
        useC    = 1'b0;
        if (shamt == '0) begin
            useC = 1'b1;
        end else begin
            case (shift_type)
                2'b00: begin shOut = lslWide[WIDTH-1:0]; shC = lslWide[WIDTH]; end
                2'b01: begin shOut = lsrWide[WIDTH:1];   shC = lsrWide[0];     end
                2'b10: begin shOut = asrWide[WIDTH:1];   shC = asrWide[0];     end
                default: begin shOut = rotVal;           shC = rotVal[WIDTH-1]; end
            endcase
        end
    end

    // S2 datapath works against the live flag register, so ADC/SBC and
    // shamt==0 carries always see the previous instruction's flags.
    logic [WIDTH-1:0] addX;
    logic [WIDTH-1:0] addY;
    logic             addCin;
    logic             isArith;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] aluRes;
    logic             effShC;
    logic [3:0]       newFlags;

    always_comb begin
        addX    = s1A;
        addY    = s1B;
        addCin  = 1'b0;
        isArith = 1'b1;
        case (s1Op)
            4'd2, 4'd10: begin addY = ~s1B; addCin = 1'b1; end
            4'd3:        begin addX = s1B; addY = ~s1A; addCin = 1'b1; end
            4'd4, 4'd11: begin end
            4'd5:        addCin = flags[1];
            4'd6:        begin addY = ~s1B; addCin = flags[1]; end
            4'd7:        begin addX = s1B; addY = ~s1A; addCin = flags[1]; end
            default:     isArith = 1'b0;
        endcase
        sum = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
        ovf = (addX[WIDTH-1] == addY[WIDTH-1]) && (sum[WIDTH-1] != addX[WIDTH-1]);

        case (s1Op)
            4'd0, 4'd8: aluRes = s1A & s1B;
            4'd1, 4'd9: aluRes = s1A ^ s1B;
            4'd12:      aluRes = s1A | s1B;
            4'd13:      aluRes = s1B;
            4'd14:      aluRes = s1A & ~s1B;
            4'd15:      aluRes = ~s1B;
            default:    aluRes = sum[WIDTH-1:0];
        endcase

        effShC      = s1UseC ? flags[1] : s1ShC;
        newFlags[3] = aluRes[WIDTH-1];
        newFlags[2] = (aluRes == '0);
        newFlags[1] = isArith ? sum[WIDTH] : effShC;
        newFlags[0] = isArith ? ovf : flags[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            wr_en     <= 1'b0;
            flags     <= 4'b0000;
        end else begin
            if (s1Advance) begin
                s1Valid <= in_valid;
                if (in_valid) begin
                    s1A    <= op_a;
                    s1B    <= shOut;
                    s1ShC  <= shC;
                    s1UseC <= useC;
                    s1Op   <= opcode;
                    s1S    <= set_flags;
                end
            end
            if (s2Advance) begin
                out_valid <= s1Valid;
                if (s1Valid) begin
                    result <= aluRes;
                    wr_en  <= (s1Op[3:2] != 2'b10);
                    if (s1S) begin
                        flags <= newFlags;
                    end
                end
            end
        end
    end

endmodule

// File: doc/dp_alu_pipe.md
DP_ALU_PIPE -- requirements
Module: dp_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (8..64, power of two).
REQ-002 SHALL have parameter SW, default $clog2(WIDTH)+1, shift-amount width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port op_a  input  WIDTH  first operand (Rn).
REQ-008 SHALL have port op_b  input  WIDTH  second operand, pre-shift.
REQ-009 SHALL have port shamt  input  SW  shift amount.
REQ-010 SHALL have port shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-011 SHALL have port opcode  input  4  ARM data-processing opcode, AND=0000 .. MVN=1111.
REQ-012 SHALL have port set_flags  input  1  S bit.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-015 SHALL have port result  output  WIDTH  ALU result.
REQ-016 SHALL have port wr_en  output  1  1 = write back; 0 for TST/TEQ/CMP/CMN.
REQ-017 SHALL have port flags  output  4  current {N,Z,C,V} register.

Function
REQ-018 SHALL be a two-stage pipeline: S1 registers shifted operand, shifter carry and control; S2 registers result, wr_en and flag update.
REQ-019 SHALL give a latency of exactly 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-020 SHALL advance S2 when !out_valid || out_ready.
REQ-021 SHALL advance S1 when S1 is empty or S2 advances.
REQ-022 SHALL drive in_ready = S1 empty || S2 advances (combinational), sustaining one transaction per cycle.
REQ-023 SHALL hold result/wr_en stable while out_valid && !out_ready.
REQ-024 SHALL apply shamt==0 for all types as pass-through, with shifter carry = current C flag, resolved in S2.
REQ-025 SHALL handle LSL/LSR with 1<=shamt<WIDTH as logical shifts, carry = last bit shifted out.
REQ-026 SHALL handle LSL/LSR with shamt==WIDTH as result 0, carry = op_b[0] (LSL) or op_b[WIDTH-1] (LSR).
REQ-027 SHALL handle LSL/LSR with shamt>WIDTH as result 0, carry 0.
REQ-028 SHALL handle ASR with shamt>=WIDTH as all bits = op_b[WIDTH-1], carry = op_b[WIDTH-1].
REQ-029 SHALL rotate ROR by shamt mod WIDTH; carry = result MSB; a nonzero multiple of WIDTH leaves the value unchanged.
REQ-030 SHALL compute arithmetic at WIDTH+1 bits: ADD/ADC/CMN C = carry-out; SUB/RSB/SBC/RSC/CMP C = NOT borrow.
REQ-031 SHALL compute ADC as a+b+C and SBC as a-b-!C, with C from the flag register at S2 time.
REQ-032 SHALL compute V for arithmetic ops as signed overflow of the actual operation (addition: operand signs equal, result differs; subtraction: operand signs differ, result sign differs from minuend).
REQ-033 SHALL, for logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN), set C = shifter carry and leave V unchanged.
REQ-034 SHALL, when set_flags=1, update N = result MSB and Z = (result==0) at the same edge the instruction loads into S2.
REQ-035 SHALL leave flags unchanged when set_flags=0.
REQ-036 SHALL let a back-to-back ADC see the flags of the immediately preceding instruction (no hazard).
REQ-037 SHALL, for TST/TEQ/CMP/CMN, still drive result with the computed value and wr_en=0.

Reset
REQ-038 SHALL, on reset at a clock edge, clear S1/S2 valid, out_valid=0, result=0, wr_en=0, flags=4'b0000.
REQ-039 SHALL drop in-flight transactions on reset mid-operation with no output.
REQ-040 SHALL drive in_ready=0 during the reset cycle and in_ready=1 on the first cycle after reset.

Verification
REQ-041 SHALL verify: ADDS a=0x7FFFFFFF, b=1, LSL #0 -> result 0x80000000, flags N=1 Z=0 C=0 V=1, out_valid 2 cycles after accept.
REQ-042 SHALL verify: SUBS a=5, b=5 then back-to-back ADC a=1, b=1 -> first result 0 (Z=1, C=1); ADC result 3.
REQ-043 SHALL verify: MOVS b=0x80000001 LSR #32 -> result 0, C=1; ASR #40 -> 0xFFFFFFFF, C=1; ROR #32 -> 0x80000001, C=1.
REQ-044 SHALL verify: 4 back-to-back requests with out_ready low for 3 cycles -> in_ready falls after S1/S2 fill, no loss or duplication, order preserved.
REQ-045 SHALL verify: CMP a=3, b=4 -> wr_en=0, result 0xFFFFFFFF, N=1 C=0.
REQ-046 SHALL verify: reset asserted with both stages full -> next cycle out_valid=0, flags=0, in_ready=1.
REQ-047 SHALL verify: WIDTH=8, ADDS 0xFF+0x01 -> result 0x00, Z=1, C=1, V=0.
